muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller for RV32M MUL/DIV ops issued from the execute stage.
//  Captures forwarded operands (post-forwarding SrcA/SrcB) and runs an iterative
//  shift-add multiplier or restoring divider, one bit per clock.
//  Holds the pipeline via stall_req until the result is ready, then emits a
//  one-cycle done pulse with the result and destination register.
// PARAMETERS
//  XLEN        32  operand/result width; the counter is $clog2(XLEN) bits wide
//  FAST_SPECIAL 1  1: div-by-zero and signed overflow bypass iterations
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  start      in   1     execute stage issues an M-ext op this cycle
//  op         in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  src_a      in   XLEN  rs1 operand (after forwarding mux)
//  src_b      in   XLEN  rs2 operand (after forwarding mux)
//  rd_in      in   5     destination register of issued op
//  flush      in   1     abort current/issuing op (branch redirect)
//  busy       out  1     state is MUL or DIV
//  stall_req  out  1     freeze IF/ID/EX; combinational
//  done       out  1     result valid, single-cycle pulse
//  result     out  XLEN  op result; held until next accepted start
//  rd_out     out  5     destination register that goes with result
// BEHAVIOUR
//  States: IDLE, MUL, DIV, DONE. Reset -> IDLE; busy=0, done=0, result=0, rd_out=0,
//   internal accumulators and count=0.
//  Accept: in IDLE, start=1 and flush=0 at an edge latches op, rd_in, abs values,
//   sign flags. Next state: MUL for op<4, DIV otherwise. count=0.
//  start in MUL/DIV/DONE is ignored; it is not queued.
//  MUL: unsigned 32x32 shift-add into a 64-bit product, one multiplier bit per edge.
//   Sign fix: negate the product if the operand signs differ.
//   MUL and MULHU treat both operands as unsigned; MULH treats both as signed;
//   MULHSU treats src_a as signed and src_b as unsigned.
//   Result select: MUL takes product[31:0]; the others take product[63:32].
//  DIV: restoring divide of |a| by |b|; one quotient bit per edge.
//   DIV/REM: quotient sign = sa^sb; remainder sign = sign of dividend.
//   DIVU/REMU use raw unsigned operands.
//  Iterations: XLEN edges in MUL/DIV (count 0..XLEN-1). At count==XLEN-1 go to DONE.
//  DONE: done=1 for exactly one cycle; result/rd_out valid; next edge -> IDLE.
//  Latency: accept at edge E0 -> done high in the cycle after edge E0+XLEN (33 cycles).
//  Special cases with FAST_SPECIAL=1 go from accept straight to DONE (done in cycle after E0):
//   - b==0: DIV/DIVU=all ones, REM/REMU=a.
//   - DIV with a=0x80000000 and b=-1 gives 0x80000000; REM gives 0.
//  With FAST_SPECIAL=0, the iterative path must produce the same values.
//  stall_req = busy | (state==IDLE & start & ~flush). It is 0 in DONE, so EX
//   advances while done=1 and writeback takes result that cycle.
//  Flush: in MUL/DIV at an edge -> IDLE, no done pulse, result unchanged.
//   In DONE, done still fires (that op has already committed).
//   If flush and start arrive together in IDLE, flush wins.
//  Reset mid-operation: immediate return to IDLE, outputs at reset values, no done.
//  result is not updated on abort; it changes only on entry to DONE.
// TESTING
//  MUL 7*6, rd=5:
//   stall_req=1 for 33 cycles from issue; done in cycle 33; result=42; rd_out=5.
//  MULH 0x80000000*0x80000000 -> 0x40000000.
//  MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV -100/7 -> 0xFFFFFFF2 (-14); REM -100/7 -> 0xFFFFFFFE (-2); DIVU 100/7 -> 14.
//  Divide by zero, FAST_SPECIAL=1:
//   DIVU 55/0 -> 0xFFFFFFFF with done 1 cycle after accept; REMU 55/0 -> 55.
//   Overflow DIV 0x80000000/-1 -> 0x80000000.
//  Abort paths:
//   flush at iteration 10 of DIV -> busy=0 next cycle, no done, result keeps old value.
//   start while busy is ignored.
//  Reset and back-to-back:
//   rst pulse mid-MUL -> all outputs 0 asynchronously.
//   Back-to-back ops (start asserted in the DONE cycle) -> second op accepted
//   only after IDLE; both results are correct.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// RV32M iterative MUL/DIV: one bit per clock, done pulse XLEN+1 cycles after accept (1 for fast specials).
// Backpressure: stall_req holds IF/ID/EX while busy or while an op is being issued; starts during busy/done are dropped.
module muldiv_sequencer #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept, signed_a, signed_b, sa, sb;
  logic                div_zero, div_ovf, special, last_iter;
  logic [XLEN-1:0]     a_abs, b_abs, special_res;
  logic [XLEN:0]       mul_sum, div_sh;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff, div_sel, div_fin, iter_res;
  logic [2*XLEN-1:0]   mul_step, div_step, prod_fix;

  // Operand decode at issue: magnitudes for the unsigned core, sign kept in neg_q
  always_comb begin
    accept   = (state_q == S_IDLE) && start && !flush;
    signed_a = (op == 3'd1) || (op == 3'd2) || (op[2] && !op[0]);
    signed_b = (op == 3'd1) || (op[2] && !op[0]);
    sa       = signed_a && src_a[XLEN-1];
    sb       = signed_b && src_b[XLEN-1];
    a_abs    = sa ? -src_a : src_a;
    b_abs    = sb ? -src_b : src_b;
    div_zero = (src_b == '0);
    div_ovf  = op[2] && !op[0] && (src_a == MIN_NEG) && (src_b == {XLEN{1'b1}});
    special  = FAST_SPECIAL && op[2] && (div_zero || div_ovf);
    if (div_zero) special_res = op[1] ? src_a : {XLEN{1'b1}};
    else          special_res = op[1] ? '0 : MIN_NEG;
    last_iter = (count_q == CW'(XLEN-1));
  end

  // acc_q = {hi, lo}: MUL shifts the multiplier out of lo; DIV shifts the dividend out of lo into the remainder
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    div_step = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    prod_fix = neg_q ? -mul_step : mul_step;
    div_sel  = op_q[1] ? div_step[2*XLEN-1:XLEN] : div_step[XLEN-1:0];
    div_fin  = neg_q ? -div_sel : div_sel;
    if (op_q[2])             iter_res = div_fin;
    else if (op_q == 3'd0)   iter_res = prod_fix[XLEN-1:0];
    else                     iter_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    count_d  = count_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          rd_d    = rd_in;
          count_d = '0;
          opnd_d  = op[2] ? b_abs : a_abs;
          acc_d   = {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
          // A zero divisor yields all-ones quotient unsigned; never negate it
          if (!op[2])      neg_d = sa ^ sb;
          else if (!op[1]) neg_d = (sa ^ sb) && !div_zero;
          else             neg_d = sa;
          if (special) begin
            result_d = special_res;
            rd_out_d = rd_in;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d   = (state_q == S_MUL) ? mul_step : div_step;
        count_d = count_q + CW'(1);
        if (last_iter && !flush) begin
          result_d = iter_res;
          rd_out_d = rd_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      count_q  <= count_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special)    state_d = S_DONE;
          else if (op[2]) state_d = S_DIV;
          else            state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_MUL) || (state_q == S_DIV);
    done      = (state_q == S_DONE);
    stall_req = busy || ((state_q == S_IDLE) && start && !flush);
    result    = result_q;
    rd_out    = rd_out_q;
  end

endmodule
